// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_pkg
// Purpose  : Shared defaults and word/address types for the bram block.
//            Exports DEF_ADDR_W, DEF_DATA_W, addr_t and data_t.
// Revision : 1.0 - initial release
// ============================================================================
package bram_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;

endpackage : bram_pkg
`default_nettype wire

// File: rtl/bram_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_if
// Purpose  : Bundle of the bram write port, read port and read result.
// Ports    : clk, reset_n (interface ports)
//            we, wr_addr, din   - write port
//            rd_addr            - read address, sampled every cycle
//            dout, dout_vld     - read result and its valid flag
// Modports : dut (memory side), tb (driver side)
// Revision : 1.0 - initial release
// ============================================================================
interface bram_if
    import bram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic clk,
    input logic reset_n
);

    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] dout;
    logic              dout_vld;

    modport dut (
        input  clk,
        input  reset_n,
        input  we,
        input  wr_addr,
        input  din,
        input  rd_addr,
        output dout,
        output dout_vld
    );

    modport tb (
        input  clk,
        input  reset_n,
        output we,
        output wr_addr,
        output din,
        output rd_addr,
        input  dout,
        input  dout_vld
    );

endinterface : bram_if
`default_nettype wire

// File: rtl/bram.sv
`default_nettype none
// ============================================================================
// Module   : bram
// Purpose  : Simple dual-port RAM, one write and one read port on one clock.
//            Never-written words read as zero via a per-word written flag.
//            Same-edge write/read of one address is write-first.
// Ports    : bus (bram_if.dut) - clk, reset_n, we, wr_addr, din, rd_addr,
//                                dout, dout_vld
// Params   : ADDR_W, DATA_W - must match the connected bram_if
//            RD_LAT         - 1 or 2 (2 adds an output register)
// Revision : 1.0 - initial release
// ============================================================================
module bram
    import bram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    bram_if.dut bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;

    // An X/Z on we compares as unknown and is treated as "no write".
    logic wr_en;
    assign wr_en = (bus.we == 1'b1);

    // Array has no reset so it maps onto block RAM. Gating with reset_n drops
    // a write that coincides with a reset assertion.
    always_ff @(posedge bus.clk) begin
        if (wr_en && bus.reset_n) begin
            mem[bus.wr_addr] <= bus.din;
        end
    end

    always_ff @(posedge bus.clk or negedge bus.reset_n) begin
        if (!bus.reset_n) begin
            written <= '0;
        end else if (wr_en) begin
            written[bus.wr_addr] <= 1'b1;
        end
    end

    // Stage 1: raw synchronous array read plus side information that lets the
    // output mux override it (same-edge write bypass, never-written mask).
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] byp_data;
    logic              byp_hit;
    logic              flag_q;
    logic              vld1;

    always_ff @(posedge bus.clk) begin
        mem_q    <= mem[bus.rd_addr];
        byp_data <= bus.din;
    end

    always_ff @(posedge bus.clk or negedge bus.reset_n) begin
        if (!bus.reset_n) begin
            byp_hit <= 1'b0;
            flag_q  <= 1'b0;
            vld1    <= 1'b0;
        end else begin
            byp_hit <= wr_en && (bus.wr_addr == bus.rd_addr);
            flag_q  <= written[bus.rd_addr];
            vld1    <= 1'b1;
        end
    end

    // vld1 is async-cleared, so the result is forced to zero the moment reset
    // asserts, discarding any read in flight.
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (vld1) begin
            if (byp_hit) begin
                rd_data = byp_data;
            end else if (flag_q) begin
                rd_data = mem_q;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] dout_q;
        logic              vld2;

        always_ff @(posedge bus.clk or negedge bus.reset_n) begin
            if (!bus.reset_n) begin
                dout_q <= '0;
                vld2   <= 1'b0;
            end else begin
                dout_q <= rd_data;
                vld2   <= vld1;
            end
        end

        assign bus.dout     = dout_q;
        assign bus.dout_vld = vld2;
    end else begin : g_lat1
        assign bus.dout     = rd_data;
        assign bus.dout_vld = vld1;
    end

    we_known : assert property (@(posedge bus.clk) disable iff (!bus.reset_n)
                                !$isunknown(bus.we))
        else $error("bram: write enable is X/Z while out of reset");

endmodule : bram
`default_nettype wire

// File: tb/tb_bram.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram
// Purpose  : Self-checking bench for bram. A reference model computes the
//            expected word for every read issued; the expectation is queued
//            and popped once the read latency has elapsed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram;
    import bram_pkg::*;

    localparam int LAT = 1;

    logic clk;
    logic reset_n;

    int total = 0;
    int bad   = 0;

    data_t exp_q[$];
    data_t ref_mem [256];
    logic  ref_wr  [256];

    bram_if #(.ADDR_W(DEF_ADDR_W), .DATA_W(DEF_DATA_W)) bus (
        .clk     (clk),
        .reset_n (reset_n)
    );

    bram #(.ADDR_W(DEF_ADDR_W), .DATA_W(DEF_DATA_W), .RD_LAT(LAT)) dut (
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input data_t obs, input data_t exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, model the read, sample #1 after posedge.
    task automatic step(input logic we, input addr_t wa, input data_t d,
                        input addr_t ra, input string tag);
        data_t e;
        @(negedge clk);
        bus.we      = we;
        bus.wr_addr = wa;
        bus.din     = d;
        bus.rd_addr = ra;
        if (we && (wa == ra))  e = d;
        else if (ref_wr[ra])   e = ref_mem[ra];
        else                   e = '0;
        exp_q.push_back(e);
        if (we) begin
            ref_mem[wa] = d;
            ref_wr[wa]  = 1'b1;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == LAT) begin
            e = exp_q.pop_front();
            check({tag, "_vld"}, {31'd0, bus.dout_vld}, 32'd1);
            check(tag, bus.dout, e);
        end
    endtask

    function automatic addr_t pick_addr();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return addr_t'($urandom_range(0, 7));
            default: return addr_t'($urandom_range(0, 255));
        endcase
    endfunction

    // Release reset at a negedge and check dout_vld rises after exactly LAT edges.
    task automatic release_and_check_vld();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("vld_before_lat", {31'd0, bus.dout_vld}, 32'd0);
        @(posedge clk);
        #1;
        check("vld_at_lat", {31'd0, bus.dout_vld}, 32'd1);
    endtask

    initial begin
        addr_t wa;
        addr_t ra;
        logic  we;
        data_t d;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = '0;
            ref_wr[i]  = 1'b0;
        end

        // 1. reset held for 10 ns
        reset_n     = 1'b0;
        bus.we      = 1'b0;
        bus.wr_addr = '0;
        bus.din     = '0;
        bus.rd_addr = '0;
        #7;
        check("rst_dout", bus.dout, 32'd0);
        check("rst_vld", {31'd0, bus.dout_vld}, 32'd0);
        release_and_check_vld();

        // 2. never-written address
        step(1'b0, 8'h00, 32'h0, 8'h10, "unwritten_10");

        // 3. write then read
        step(1'b1, 8'h05, 32'hDEADBEEF, 8'h10, "wr05_rd10");
        step(1'b0, 8'h00, 32'h0, 8'h05, "rd05");

        // 4. same-edge collision, write-first
        step(1'b1, 8'h3C, 32'h12345678, 8'h3C, "collide_3c");

        // 5. boundary addresses
        step(1'b1, 8'hFF, 32'h000000A5, 8'h05, "wrff_rd05");
        step(1'b1, 8'h00, 32'h0000005A, 8'hFF, "wr00_rdff");
        step(1'b0, 8'h00, 32'h0, 8'h00, "rd00");
        step(1'b0, 8'h00, 32'h0, 8'hFF, "rdff");

        // back-to-back writes to one address, last wins
        step(1'b1, 8'h20, 32'h11111111, 8'h00, "b2b_1");
        step(1'b1, 8'h20, 32'h22222222, 8'h00, "b2b_2");
        step(1'b0, 8'h00, 32'h0, 8'h20, "b2b_rd");

        // 6. constrained-random vectors
        for (int n = 0; n < 100; n++) begin
            we = 1'($urandom_range(0, 1));
            wa = pick_addr();
            ra = ($urandom_range(0, 9) < 3) ? wa : pick_addr();
            d  = $urandom();
            step(we, wa, d, ra, "rand");
        end

        // reset mid-stream with a write on the asserting edge
        @(negedge clk);
        bus.we      = 1'b1;
        bus.wr_addr = 8'h77;
        bus.din     = 32'hCAFEF00D;
        bus.rd_addr = 8'h05;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_dout", bus.dout, 32'd0);
        check("midrst_vld", {31'd0, bus.dout_vld}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_dout_edge", bus.dout, 32'd0);
        bus.we = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) ref_wr[i] = 1'b0;
        release_and_check_vld();

        step(1'b0, 8'h00, 32'h0, 8'h05, "post_rst_05");
        step(1'b0, 8'h00, 32'h0, 8'hFF, "post_rst_ff");
        step(1'b0, 8'h00, 32'h0, 8'h20, "post_rst_20");
        step(1'b0, 8'h00, 32'h0, 8'h77, "post_rst_77");
        step(1'b1, 8'h42, 32'h0BADF00D, 8'h42, "post_rst_collide");

        for (int n = 0; n < LAT; n++)
            step(1'b0, 8'h00, 32'h0, 8'h42, "flush");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule : tb_bram
`default_nettype wire
